// File: rtl/alu_issue_pkg.sv
// ----------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the operand issue stage and its register file:
//   - default operand width and register/memory address width
//   - 3-bit ALU operation select codes
//   - issue-stage FSM state encoding (RUN / STALL)
// ----------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } issue_state_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
// Register file with two asynchronous read ports and one synchronous write
// port. Entry 0 always reads 0 and ignores writes. Reads are write-first: a
// write to the addressed entry in the same cycle is forwarded to the read port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all entries)
//   we, waddr, wdata    write port
//   raddr_a / rdata_a   read port A
//   raddr_b / rdata_b   read port B
// ----------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// ----------------------------------------------------------------------------
// operand_issue_stage
// Accepts decoded instructions (valid/ready), reads both operands from the
// internal register file and drives a registered operand bundle to the
// ALU/data-memory stage. A per-register pending scoreboard holds back
// RAW/WAW hazards until the consumer writes the result back on wb_*.
// Optional feature macro: ISSUE_STALL_CNT_EN adds a saturating 32-bit
// stall_cnt output counting cycles spent in STALL.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid / in_ready                instruction handshake
//   in_rs, in_rt, in_rd                source / destination registers
//   in_sel, in_ewr, in_wb              ALU select, memory write, write-back flag
//   out_valid                          one-cycle pulse per issued bundle
//   out_Op1, out_Op2, out_Sel, out_Dir operand bundle (held between issues)
//   out_Ewr                            memory write enable (only with out_valid)
//   wb_en, wb_addr, wb_data            result write-back port
//   stall_cnt                          (ISSUE_STALL_CNT_EN only) stall cycles
// ----------------------------------------------------------------------------
module operand_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [2:0]        in_sel,
    input  logic              in_ewr,
    input  logic              in_wb,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_Op1,
    output logic [DATA_W-1:0] out_Op2,
    output logic [2:0]        out_Sel,
    output logic [ADDR_W-1:0] out_Dir,
    output logic              out_Ewr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    issue_state_t state, state_next;

    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  wb_clr;
    logic [DEPTH-1:0]  pend_eff;
    logic [DEPTH-1:0]  pend_set;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    reg_file_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (in_rs),
        .rdata_a (rd_a),
        .raddr_b (in_rt),
        .rdata_b (rd_b)
    );

    // A write-back arriving this cycle already resolves its register's hazard.
    always_comb begin
        wb_clr = '0;
        if (wb_en) begin
            wb_clr[wb_addr] = 1'b1;
        end
        pend_eff = pending & ~wb_clr;
        hazard   = pend_eff[in_rs] | pend_eff[in_rt] | (in_wb & pend_eff[in_rd]);
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        pend_set = '0;
        if (accept && in_wb && (in_rd != '0)) begin
            pend_set[in_rd] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a same-cycle set of the same register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_clr) | pend_set;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:   if (in_valid && hazard) state_next = STALL;
            STALL: if (!in_valid || !hazard) state_next = RUN;
        endcase
    end

    // FSM: outputs
`ifdef ISSUE_STALL_CNT_EN
    logic stall_tick;
`endif
    always_comb begin
        in_ready = 1'b0;
`ifdef ISSUE_STALL_CNT_EN
        stall_tick = 1'b0;
`endif
        unique case (state)
            RUN:   in_ready = ~hazard;
            STALL: begin
                in_ready = ~hazard;
`ifdef ISSUE_STALL_CNT_EN
                stall_tick = 1'b1;
`endif
            end
        endcase
    end

`ifdef ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_tick && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    // Output bundle: operands/select/address hold, valid and write enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_Op1   <= '0;
            out_Op2   <= '0;
            out_Sel   <= '0;
            out_Dir   <= '0;
            out_Ewr   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_Op1   <= rd_a;
            out_Op2   <= rd_b;
            out_Sel   <= in_sel;
            out_Dir   <= in_rd;
            out_Ewr   <= in_ewr;
        end else begin
            out_valid <= 1'b0;
            out_Ewr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
module tb_operand_issue_stage;
    import alu_issue_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [2:0]  in_sel;
    logic        in_ewr;
    logic        in_wb;
    logic        out_valid;
    logic [31:0] out_Op1;
    logic [31:0] out_Op2;
    logic [2:0]  out_Sel;
    logic [4:0]  out_Dir;
    logic        out_Ewr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    operand_issue_stage #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_sel    (in_sel),
        .in_ewr    (in_ewr),
        .in_wb     (in_wb),
        .out_valid (out_valid),
        .out_Op1   (out_Op1),
        .out_Op2   (out_Op2),
        .out_Sel   (out_Sel),
        .out_Dir   (out_Dir),
        .out_Ewr   (out_Ewr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  sel;
        logic [4:0]  dir;
        logic        ewr;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: every issued bundle is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_Op1", out_Op1, e.op1);
                    chk("out_Op2", out_Op2, e.op2);
                    chk("out_Sel", {29'd0, out_Sel}, {29'd0, e.sel});
                    chk("out_Dir", {27'd0, out_Dir}, {27'd0, e.dir});
                    chk("out_Ewr", {31'd0, out_Ewr}, {31'd0, e.ewr});
                end
            end else begin
                chk("out_Ewr_idle", {31'd0, out_Ewr}, 32'd0);
            end
        end
    end

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] sel, input logic ewr, input logic wbf);
        in_valid = 1'b1;
        in_rs = rs; in_rt = rt; in_rd = rd;
        in_sel = sel; in_ewr = ewr; in_wb = wbf;
    endtask

    // Present, require acceptance this cycle, record expected bundle.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] sel, input logic ewr, input logic wbf,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        present(rs, rt, rd, sel, ewr, wbf);
        @(negedge clk);
        chk("in_ready_issue", {31'd0, in_ready}, 32'd1);
        e.op1 = e1; e.op2 = e2; e.sel = sel; e.dir = rd; e.ewr = ewr;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic expect_stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Accept a stalled instruction in the same cycle as its resolving write-back.
    task automatic wb_release(input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] e1, input logic [31:0] e2);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        issue(in_rs, in_rt, in_rd, in_sel, in_ewr, in_wb, e1, e2);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_Op1", out_Op1, 32'd0);
        chk("rst_out_Op2", out_Op2, 32'd0);
        chk("rst_out_Sel", {29'd0, out_Sel}, 32'd0);
        chk("rst_out_Dir", {27'd0, out_Dir}, 32'd0);
        chk("rst_out_Ewr", {31'd0, out_Ewr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ISSUE_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_sel = '0; in_ewr = 1'b0; in_wb = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Power-on reset with a hazard-free instruction offered.
        present(5'd1, 5'd2, 5'd3, ALU_ADD, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Basic issue with write-backs to non-pending registers.
        wb(5'd3, 32'h10);
        wb(5'd4, 32'h20);
        issue(5'd3, 5'd4, 5'd5, ALU_ADD, 1'b1, 1'b0, 32'h10, 32'h20);

        // RAW: reader of r7 waits 3 cycles, released by same-cycle write-back.
        issue(5'd0, 5'd0, 5'd7, ALU_SUB, 1'b0, 1'b1, 32'h0, 32'h0);
        present(5'd7, 5'd3, 5'd8, ALU_OR, 1'b0, 1'b0);
        expect_stall(3);
        wb_release(5'd7, 32'hABCD, 32'hABCD, 32'h10);
`ifdef ISSUE_STALL_CNT_EN
        chk("stall_cnt_raw", stall_cnt, 32'd3);
`endif

        // WAW: second writer of r9 waits; its pending set beats the same-cycle clear.
        issue(5'd3, 5'd4, 5'd9, ALU_AND, 1'b0, 1'b1, 32'h10, 32'h20);
        present(5'd4, 5'd3, 5'd9, ALU_SLT, 1'b1, 1'b1);
        expect_stall(2);
        wb_release(5'd9, 32'h55, 32'h20, 32'h10);
        present(5'd9, 5'd0, 5'd2, ALU_OR, 1'b0, 1'b0);
        expect_stall(1);
        wb_release(5'd9, 32'h66, 32'h66, 32'h0);

        // r0: writes ignored (including same-cycle bypass), rd=0 never marks pending.
        wb(5'd0, 32'hFFFF);
        issue(5'd0, 5'd9, 5'd0, ALU_XOR, 1'b0, 1'b1, 32'h0, 32'h66);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        issue(5'd0, 5'd7, 5'd0, ALU_ADD, 1'b0, 1'b1, 32'h0, 32'hABCD);
        issue(5'd0, 5'd0, 5'd1, ALU_ADD, 1'b0, 1'b0, 32'h0, 32'h0);

        // Back-to-back independent issues, then output hold.
        issue(5'd3, 5'd4, 5'd10, ALU_SUB, 1'b1, 1'b1, 32'h10, 32'h20);
        issue(5'd4, 5'd7, 5'd11, ALU_SLL, 1'b0, 1'b0, 32'h20, 32'hABCD);
        issue(5'd7, 5'd3, 5'd12, ALU_SRL, 1'b1, 1'b0, 32'hABCD, 32'h10);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_Op1", out_Op1, 32'hABCD);
        chk("hold_Dir", {27'd0, out_Dir}, 32'd12);
        @(posedge clk); #1;

        // Reset while a reader of r13 is stalled.
        issue(5'd3, 5'd4, 5'd13, ALU_ADD, 1'b0, 1'b1, 32'h10, 32'h20);
        present(5'd13, 5'd0, 5'd14, ALU_ADD, 1'b1, 1'b0);
        expect_stall(1);
        @(negedge clk);
        chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Register file cleared by reset.
        issue(5'd3, 5'd4, 5'd1, ALU_XOR, 1'b1, 1'b0, 32'h0, 32'h0);
        issue(5'd7, 5'd9, 5'd2, ALU_AND, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
